// File: rtl/retospect_lif_cell_if.sv
// Bundle of the neuron cell's network-facing signals: network reset,
// configuration chain, decay bus, dendrites, axon, potential and FSM debug view.
//
// Chain protocol: there is no valid/ready pair. While config_en is high,
// one bit is taken from bs_in on every clk edge. bs_out always shows the
// current chain tail and is valid combinationally from the cell's register.
interface retospect_lif_cell_if #(
  parameter int NUM_DEND = 4,
  parameter int POT_BITS = 6,
  parameter int SEL_BITS = 3
);
  logic                       reset_nn;
  logic                       config_en;
  logic                       bs_in;
  logic                       bs_out;
  logic [(2**SEL_BITS)-1:0]   clockbus;
  logic [NUM_DEND-1:0]        dendrite;
  logic                       axon;
  logic signed [POT_BITS-1:0] pot;
  // FSM debug view: 0 = INTEGRATE, 1 = FIRE, 2 = REFRACT
  logic [1:0]                 fsm_state;

  modport master (
    output reset_nn, config_en, bs_in, clockbus, dendrite,
    input  bs_out, axon, pot, fsm_state
  );

  modport slave (
    input  reset_nn, config_en, bs_in, clockbus, dendrite,
    output bs_out, axon, pot, fsm_state
  );
endinterface

// File: rtl/retospect_lif_cell.sv
// Leaky integrate-and-fire neuron cell with signed dendrite weights,
// programmable threshold, saturating membrane potential and a refractory
// period. Configuration arrives through a serial shift chain.
module retospect_lif_cell #(
  parameter int NUM_DEND  = 4,
  parameter int W_BITS    = 4,
  parameter int POT_BITS  = 6,
  parameter int REFR_BITS = 3,
  parameter int SEL_BITS  = 3
) (
  input  logic clk,
  input  logic reset,
  retospect_lif_cell_if.slave lif
);

  localparam int THR_BITS = POT_BITS - 1;
  localparam int CFG_LEN  = NUM_DEND * W_BITS + THR_BITS + REFR_BITS + SEL_BITS;
  localparam int OFF_REFR = SEL_BITS;
  localparam int OFF_THR  = SEL_BITS + REFR_BITS;
  localparam int OFF_W    = OFF_THR + THR_BITS;
  // Wide enough that leaked potential plus every weight cannot overflow.
  localparam int SUM_W    = POT_BITS + W_BITS + $clog2(NUM_DEND);

  localparam logic signed [SUM_W-1:0] MAX_W = SUM_W'((2 ** (POT_BITS - 1)) - 1);
  localparam logic signed [SUM_W-1:0] MIN_W = SUM_W'(-(2 ** (POT_BITS - 1)));
  localparam logic signed [POT_BITS-1:0] MAX_POT = {1'b0, {(POT_BITS-1){1'b1}}};
  localparam logic signed [POT_BITS-1:0] MIN_POT = {1'b1, {(POT_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_INTEGRATE = 2'd0,
    ST_FIRE      = 2'd1,
    ST_REFRACT   = 2'd2
  } state_t;

  // Chain layout, MSB first: w[0] .. w[NUM_DEND-1], thr, refr, dsel.
  // bs_in enters at the MSB, so the first bit shifted in ends up in dsel[0].
  logic [CFG_LEN-1:0]         cfg_q, cfg_d;
  state_t                     state_q, state_d;
  logic signed [POT_BITS-1:0] pot_q, pot_d;
  logic [REFR_BITS-1:0]       cnt_q, cnt_d;
  logic                       axon_q, axon_d;

  logic [SEL_BITS-1:0]        dsel;
  logic [REFR_BITS-1:0]       refr;
  logic [THR_BITS-1:0]        thr;
  logic signed [W_BITS-1:0]   w [NUM_DEND];

  assign dsel = cfg_q[0 +: SEL_BITS];
  assign refr = cfg_q[OFF_REFR +: REFR_BITS];
  assign thr  = cfg_q[OFF_THR +: THR_BITS];

  for (genvar gi = 0; gi < NUM_DEND; gi++) begin : g_w
    assign w[gi] = cfg_q[OFF_W + (NUM_DEND - 1 - gi) * W_BITS +: W_BITS];
  end

  logic                       decay;
  logic signed [POT_BITS-1:0] leaked;
  logic signed [SUM_W-1:0]    sum;
  logic signed [SUM_W-1:0]    next_wide;
  logic signed [POT_BITS-1:0] next_sat;
  logic                       fire_hit;

  assign decay  = lif.clockbus[dsel];
  assign leaked = decay ? (pot_q >>> 1) : pot_q;

  // Signed sum of the weights of every active dendrite.
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_DEND; i++) begin
      if (lif.dendrite[i]) begin
        sum = sum + $signed({{(SUM_W-W_BITS){w[i][W_BITS-1]}}, w[i]});
      end
    end
  end

  // Add leaked potential, saturate to the potential range, compare to threshold.
  always_comb begin
    next_wide = $signed({{(SUM_W-POT_BITS){leaked[POT_BITS-1]}}, leaked}) + sum;
    if (next_wide > MAX_W) begin
      next_sat = MAX_POT;
    end else if (next_wide < MIN_W) begin
      next_sat = MIN_POT;
    end else begin
      next_sat = next_wide[POT_BITS-1:0];
    end
    // thr is unsigned; the zero MSB keeps it non-negative in the signed compare.
    fire_hit = (next_sat >= $signed({1'b0, thr}));
  end

  // Next-state and next-output logic: reset_nn > config_en > run.
  always_comb begin
    cfg_d   = cfg_q;
    state_d = state_q;
    pot_d   = pot_q;
    cnt_d   = cnt_q;
    axon_d  = 1'b0;
    if (lif.reset_nn) begin
      state_d = ST_INTEGRATE;
      pot_d   = '0;
      cnt_d   = '0;
    end else if (lif.config_en) begin
      // Dynamic state is frozen while the chain shifts, refractory count included.
      cfg_d = {lif.bs_in, cfg_q[CFG_LEN-1:1]};
    end else begin
      unique case (state_q)
        ST_INTEGRATE: begin
          if (fire_hit) begin
            state_d = ST_FIRE;
            pot_d   = '0;
            axon_d  = 1'b1;
          end else begin
            pot_d = next_sat;
          end
        end
        ST_FIRE: begin
          if (refr == '0) begin
            state_d = ST_INTEGRATE;
          end else begin
            state_d = ST_REFRACT;
            cnt_d   = refr;
          end
        end
        ST_REFRACT: begin
          pot_d = '0;
          cnt_d = cnt_q - REFR_BITS'(1);
          if (cnt_q == REFR_BITS'(1)) begin
            state_d = ST_INTEGRATE;
          end
        end
        default: begin
          state_d = ST_INTEGRATE;
          pot_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State register; full reset also clears the configuration chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg_q   <= '0;
      state_q <= ST_INTEGRATE;
      pot_q   <= '0;
      cnt_q   <= '0;
      axon_q  <= 1'b0;
    end else begin
      cfg_q   <= cfg_d;
      state_q <= state_d;
      pot_q   <= pot_d;
      cnt_q   <= cnt_d;
      axon_q  <= axon_d;
    end
  end

  assign lif.bs_out    = cfg_q[0];
  assign lif.axon      = axon_q;
  assign lif.pot       = pot_q;
  assign lif.fsm_state = state_q;

endmodule
